// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared memory port.
// One transaction at a time: IDLE grants, BUSY waits for the memory (bounded
// by TIMEOUT cycles), DONE/ERR pulse the completion back to the winner.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_valid_i,
    input  logic                  m0_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WIDTH-1:0]      m0_wdata_i,
    output logic [WIDTH-1:0]      m0_rdata_o,
    output logic                  m0_ready_o,
    output logic                  m0_err_o,

    input  logic                  m1_valid_i,
    input  logic                  m1_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WIDTH-1:0]      m1_wdata_i,
    output logic [WIDTH-1:0]      m1_rdata_o,
    output logic                  m1_ready_o,
    output logic                  m1_err_o,

    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    input  logic                  mem_ready_i,

    output logic                  gnt_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    // Last BUSY cycle index; timer counts 0..TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                    state_q, state_d;
    logic [7:0]                timer_q, timer_d;
    logic                      prio_q, prio_d;   // last granted requester
    logic                      gnt_d, busy_d;
    logic                      mem_valid_d, mem_wr_rd_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_d;
    logic [WIDTH-1:0]          mem_wdata_d;
    logic [1:0][WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                ready_q, ready_d;
    logic [1:0]                err_q, err_d;
    logic                      pick;

    assign m0_rdata_o = rdata_q[0];
    assign m1_rdata_o = rdata_q[1];
    assign m0_ready_o = ready_q[0];
    assign m1_ready_o = ready_q[1];
    assign m0_err_o   = err_q[0];
    assign m1_err_o   = err_q[1];

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        prio_d      = prio_q;
        gnt_d       = gnt_o;
        mem_valid_d = mem_valid_o;
        mem_wr_rd_d = mem_wr_rd_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        rdata_d     = rdata_q;
        ready_d     = 2'b00;
        err_d       = 2'b00;

        // Contention goes to whoever did not win last; otherwise the lone requester.
        pick = (m0_valid_i && m1_valid_i) ? ~prio_q : m1_valid_i;

        case (state_q)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    gnt_d       = pick;
                    prio_d      = pick;
                    mem_valid_d = 1'b1;
                    mem_wr_rd_d = pick ? m1_wr_rd_i : m0_wr_rd_i;
                    mem_addr_d  = pick ? m1_addr_i  : m0_addr_i;
                    mem_wdata_d = pick ? m1_wdata_i : m0_wdata_i;
                    timer_d     = 8'd0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // Completion is checked first so a late ready still beats the timeout.
                if (mem_ready_i) begin
                    rdata_d[gnt_o] = mem_rdata_i;
                    ready_d[gnt_o] = 1'b1;
                    mem_valid_d    = 1'b0;
                    state_d        = DONE;
                end else if (timer_q == TMO_LAST) begin
                    err_d[gnt_o]   = 1'b1;
                    mem_valid_d    = 1'b0;
                    state_d        = ERR;
                end else begin
                    timer_d        = timer_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset leaves prio pointing at m1 so m0 wins first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            timer_q     <= 8'd0;
            prio_q      <= 1'b1;
            gnt_o       <= 1'b0;
            busy_o      <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_wr_rd_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_q     <= '0;
            ready_q     <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            prio_q      <= prio_d;
            gnt_o       <= gnt_d;
            busy_o      <= busy_d;
            mem_valid_o <= mem_valid_d;
            mem_wr_rd_o <= mem_wr_rd_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and completions
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_mem_arbiter;

    logic        clk_i, rst_i;
    logic        m0_valid_i, m0_wr_rd_i, m1_valid_i, m1_wr_rd_i;
    logic [5:0]  m0_addr_i, m1_addr_i;
    logic [15:0] m0_wdata_i, m1_wdata_i, m0_rdata_o, m1_rdata_o;
    logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
    logic        mem_valid_o, mem_wr_rd_o, mem_ready_i;
    logic [5:0]  mem_addr_o;
    logic [15:0] mem_wdata_o, mem_rdata_i;
    logic        gnt_o, busy_o;

    mem_arbiter #(.ADDR_WIDTH(6), .WIDTH(16), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_valid_i(m0_valid_i), .m0_wr_rd_i(m0_wr_rd_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
        .m0_err_o(m0_err_o),
        .m1_valid_i(m1_valid_i), .m1_wr_rd_i(m1_wr_rd_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
        .m1_err_o(m1_err_o),
        .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic        id;
        logic        wr;
        logic [5:0]  addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [15:0] rdata;
    } rsp_t;

    req_t        exp_req[$];
    rsp_t        exp_rsp[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_delay = 0;     // cycles into BUSY before memory answers; <0 never
    bit          always_rdy = 0;
    logic [15:0] rd_base = 16'h0;
    logic [15:0] last_rd [2];
    int          last_vlen = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, {24'd0, mem_valid_o, mem_wr_rd_o, gnt_o, busy_o,
                            m0_ready_o, m1_ready_o, m0_err_o, m1_err_o}, 32'd0);
        chk({tag, "_mem"}, {10'd0, mem_addr_o, mem_wdata_o}, 32'd0);
        chk({tag, "_rdata"}, {m0_rdata_o, m1_rdata_o}, 32'd0);
    endtask

    // Memory model: answers mem_delay cycles into each request.
    initial begin
        int rcnt;
        rcnt = 0;
        mem_ready_i = 1'b0;
        mem_rdata_i = 16'h0;
        forever begin
            @(negedge clk_i);
            if (!mem_valid_o) begin
                rcnt = 0;
                mem_ready_i = always_rdy;
            end else begin
                mem_ready_i = always_rdy | (mem_delay >= 0 && rcnt >= mem_delay);
                rcnt++;
            end
            mem_rdata_i = rd_base ^ {10'd0, mem_addr_o};
        end
    end

    // Monitor: grants, held request fields, valid length, completion pulses.
    initial begin
        bit   prev_v;
        int   vlen;
        req_t cur;
        rsp_t r;
        logic [3:0] pv, epv;
        prev_v = 0;
        vlen = 0;
        cur = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                prev_v = 0;
                vlen = 0;
                continue;
            end
            if (mem_valid_o && !prev_v) begin
                if (exp_req.size() == 0) chk("unexpected_grant", 32'd1, 32'd0);
                else begin
                    cur = exp_req.pop_front();
                    chk("gnt", {31'd0, gnt_o}, {31'd0, cur.id});
                    chk("mem_wr_rd", {31'd0, mem_wr_rd_o}, {31'd0, cur.wr});
                    chk("mem_addr", {26'd0, mem_addr_o}, {26'd0, cur.addr});
                    chk("mem_wdata", {16'd0, mem_wdata_o}, {16'd0, cur.wdata});
                end
            end else if (mem_valid_o && prev_v) begin
                chk("hold_req", {9'd0, mem_wr_rd_o, mem_addr_o, mem_wdata_o},
                                {9'd0, cur.wr, cur.addr, cur.wdata});
            end
            if (mem_valid_o) vlen++;
            else if (prev_v) begin
                last_vlen = vlen;
                vlen = 0;
            end
            prev_v = mem_valid_o;

            pv = {m1_err_o, m1_ready_o, m0_err_o, m0_ready_o};
            if (pv != 4'b0) begin
                if (exp_rsp.size() == 0) chk("spurious_pulse", {28'd0, pv}, 32'd0);
                else begin
                    r = exp_rsp.pop_front();
                    epv = r.err ? (r.id ? 4'b1000 : 4'b0010) : (r.id ? 4'b0100 : 4'b0001);
                    chk("pulse", {28'd0, pv}, {28'd0, epv});
                    chk("rdata", {16'd0, (r.id ? m1_rdata_o : m0_rdata_o)}, {16'd0, r.rdata});
                end
            end
        end
    end

    // Single-requester transaction; cyc = negedges from raising valid to the pulse.
    task automatic do_req(input bit id, input bit wr, input logic [5:0] addr,
                          input logic [15:0] wdata, input int dly, input bit scramble,
                          output int cyc);
        rsp_t r;
        bit   e;
        e = (dly < 0) || (dly >= 15);
        r.id = id;
        r.err = e;
        r.rdata = e ? last_rd[id] : (rd_base ^ {10'd0, addr});
        if (!e) last_rd[id] = r.rdata;
        exp_req.push_back('{id: id, wr: wr, addr: addr, wdata: wdata});
        exp_rsp.push_back(r);
        mem_delay = dly;
        @(negedge clk_i);
        if (id) begin
            m1_wr_rd_i = wr; m1_addr_i = addr; m1_wdata_i = wdata; m1_valid_i = 1'b1;
        end else begin
            m0_wr_rd_i = wr; m0_addr_i = addr; m0_wdata_i = wdata; m0_valid_i = 1'b1;
        end
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk_i);
            cyc++;
            if (scramble && cyc == 1) begin
                if (id) begin m1_addr_i = ~addr; m1_wdata_i = ~wdata; m1_wr_rd_i = ~wr; end
                else    begin m0_addr_i = ~addr; m0_wdata_i = ~wdata; m0_wr_rd_i = ~wr; end
            end
            if (id ? (m1_ready_o | m1_err_o) : (m0_ready_o | m0_err_o)) break;
        end
        if (cyc >= 100) chk("req_timeout", 32'd1, 32'd0);
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
    endtask

    // Both requesters read continuously; expect n grants alternating from m0.
    task automatic do_both(input int n, input logic [5:0] a0, input logic [5:0] a1);
        int   seen, cyc;
        bit   id;
        rsp_t r;
        for (int k = 0; k < n; k++) begin
            id = k[0];
            exp_req.push_back('{id: id, wr: 1'b0, addr: (id ? a1 : a0), wdata: 16'h0});
            r.id = id;
            r.err = 1'b0;
            r.rdata = rd_base ^ {10'd0, (id ? a1 : a0)};
            last_rd[id] = r.rdata;
            exp_rsp.push_back(r);
        end
        mem_delay = 0;
        @(negedge clk_i);
        m0_wr_rd_i = 1'b0; m0_addr_i = a0; m0_wdata_i = 16'h0; m0_valid_i = 1'b1;
        m1_wr_rd_i = 1'b0; m1_addr_i = a1; m1_wdata_i = 16'h0; m1_valid_i = 1'b1;
        seen = 0;
        cyc = 0;
        while (seen < n && cyc < 40 * n) begin
            @(negedge clk_i);
            cyc++;
            if (m0_ready_o | m1_ready_o) seen++;
        end
        if (seen < n) chk("both_timeout", 32'd1, 32'd0);
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        m0_valid_i = 0; m0_wr_rd_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
        m1_valid_i = 0; m1_wr_rd_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;

        // Round robin from reset: m0, m1, m0, m1.
        rd_base = 16'hBEEF;
        do_both(4, 6'h01, 6'h02);

        // m0 write, memory answers one cycle into BUSY.
        do_req(1'b0, 1'b1, 6'h05, 16'hA5A5, 1, 1'b0, cyc);
        chk("wr_latency", cyc, 3);

        // m1 read of top address returns 0x1234.
        rd_base = 16'h1234 ^ 16'h003F;
        do_req(1'b1, 1'b0, 6'h3F, 16'h0, 0, 1'b0, cyc);
        chk("rd_latency", cyc, 2);

        // Timeout: memory never answers; rdata must stay at 0x1234.
        rd_base = 16'h7777;
        do_req(1'b1, 1'b0, 6'h10, 16'h0, -1, 1'b0, cyc);
        @(negedge clk_i);
        chk("tmo_vlen", last_vlen, 15);
        chk("tmo_busy", {31'd0, busy_o}, 32'd0);
        chk("tmo_rdata_kept", {16'd0, m1_rdata_o}, 32'h1234);

        // Ready on the last BUSY cycle completes normally.
        do_req(1'b0, 1'b0, 6'h22, 16'h0, 14, 1'b0, cyc);
        @(negedge clk_i);
        chk("late_vlen", last_vlen, 15);

        // Requester inputs change mid-BUSY; monitor checks the held request.
        rd_base = 16'h0F0F;
        do_req(1'b1, 1'b1, 6'h2A, 16'h5A5A, 3, 1'b1, cyc);

        // Memory ready held high: ignored in IDLE, minimum latency otherwise.
        always_rdy = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("idle_ignore_rdy", {30'd0, busy_o, mem_valid_o}, 32'd0);
        do_req(1'b0, 1'b0, 6'h09, 16'h0, 0, 1'b0, cyc);
        chk("min_latency", cyc, 2);
        always_rdy = 1'b0;

        // Reset in the middle of an m0 transaction.
        mem_delay = -1;
        exp_req.push_back('{id: 1'b0, wr: 1'b1, addr: 6'h11, wdata: 16'hCAFE});
        @(negedge clk_i);
        m0_wr_rd_i = 1'b1; m0_addr_i = 6'h11; m0_wdata_i = 16'hCAFE; m0_valid_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1 chk_reset_vals("mid_reset");
        m0_valid_i = 1'b0;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("post_rst_idle", {31'd0, busy_o}, 32'd0);
        rd_base = 16'h3C3C;
        do_both(2, 6'h03, 6'h04);

        repeat (3) @(negedge clk_i);
        chk("req_queue_empty", exp_req.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
